// File: rtl/opmux_pipe.sv
// Operand-select stage: picks one of NSRC forwarding sources and registers it behind
// a valid/ready handshake with a one-entry skid buffer. Define OPMUX_ERRCNT_EN for the illegal-select counter.
module opmux_pipe #(
    parameter int WIDTH = 16,
    parameter int NSRC  = 3,
    parameter int SELW  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NSRC*WIDTH-1:0] src,
    input  logic [SELW-1:0]       ALUSrc,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [WIDTH-1:0]      op,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  sel_err,
    output logic [7:0]            err_cnt
);

    logic [WIDTH-1:0] r_op;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_skid;
    logic             r_skid_full;
    logic             r_in_ready;
    logic             r_sel_err;

    logic [WIDTH-1:0] w_data;
    logic             w_sel_legal;
    logic             w_accept;
    logic             w_consume;
    logic [WIDTH-1:0] w_op_nxt;
    logic             w_out_valid_nxt;
    logic [WIDTH-1:0] w_skid_nxt;
    logic             w_skid_full_nxt;

    assign w_accept  = in_valid & r_in_ready;
    assign w_consume = r_out_valid & out_ready;

    // Select codes at or above NSRC fall through to zero and are flagged illegal.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
        w_data      = '0;
        w_sel_legal = 1'b0;
        for (int k = 0; k < NSRC; k++) begin
            if (ALUSrc == SELW'(k)) begin
                w_data      = src[k*WIDTH +: WIDTH];
                w_sel_legal = 1'b1;
            end
        end
    end

    always_comb begin
        w_op_nxt        = r_op;
        w_out_valid_nxt = r_out_valid;
        w_skid_nxt      = r_skid;
        w_skid_full_nxt = r_skid_full;
        if (w_consume) begin
            if (r_skid_full) begin
                w_op_nxt        = r_skid;
                w_skid_full_nxt = w_accept;
                if (w_accept) begin
                    w_skid_nxt = w_data;
                end
            end else if (w_accept) begin
                w_op_nxt = w_data;
            end else begin
                w_out_valid_nxt = 1'b0;
            end
        end else if (w_accept) begin
            if (r_out_valid) begin
                w_skid_nxt      = w_data;
                w_skid_full_nxt = 1'b1;
            end else begin
                w_op_nxt        = w_data;
                w_out_valid_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            r_op        <= '0;
            r_out_valid <= 1'b0;
            r_skid      <= '0;
            r_skid_full <= 1'b0;
            r_in_ready  <= 1'b1;
            r_sel_err   <= 1'b0;
        end else begin
            r_op        <= w_op_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_skid      <= w_skid_nxt;
            r_skid_full <= w_skid_full_nxt;
            r_in_ready  <= ~w_skid_full_nxt;
            if (w_accept && !w_sel_legal) begin
                r_sel_err <= 1'b1;
            end
        end
    end

`ifdef OPMUX_ERRCNT_EN
    logic [7:0] r_err_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_cnt <= 8'h00;
        end else if (w_accept && !w_sel_legal && r_err_cnt != 8'hFF) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign err_cnt = r_err_cnt;
`else
    assign err_cnt = 8'h00;
`endif

    assign in_ready  = r_in_ready;
    assign op        = r_op;
    assign out_valid = r_out_valid;
    assign sel_err   = r_sel_err;

endmodule

// File: tb/tb_opmux_pipe.sv
// Scoreboard bench for opmux_pipe: directed scenarios followed by random traffic
// against a queue-based reference model. Expected err_cnt follows OPMUX_ERRCNT_EN.
module tb_opmux_pipe;

    localparam int WIDTH = 16;
    localparam int NSRC  = 3;
    localparam int SELW  = 3;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NSRC*WIDTH-1:0] src;
    logic [SELW-1:0]       ALUSrc;
    logic                  in_valid;
    logic                  in_ready;
    logic [WIDTH-1:0]      op;
    logic                  out_valid;
    logic                  out_ready;
    logic                  sel_err;
    logic [7:0]            err_cnt;

    opmux_pipe #(.WIDTH(WIDTH), .NSRC(NSRC), .SELW(SELW)) dut (
        .clk(clk), .rst(rst), .src(src), .ALUSrc(ALUSrc),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .sel_err(sel_err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int               vectors    = 0;
    int               miscompares = 0;
    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] last_out;
    logic             pend_valid;
    logic             pend_illegal;
    logic             exp_sel_err;
    int               exp_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the operand is simply word 'sel' of the source bus, or zero when sel is out of range.
    function automatic logic [WIDTH-1:0] ref_operand(input logic [NSRC*WIDTH-1:0] s, input int sel);
        logic [WIDTH-1:0] words[NSRC];
        for (int i = 0; i < NSRC; i++) words[i] = s[i*WIDTH +: WIDTH];
        return (sel < NSRC) ? words[sel] : '0;
    endfunction

    function automatic int exp_err_cnt();
`ifdef OPMUX_ERRCNT_EN
        return exp_cnt;
`else
        return 0;
`endif
    endfunction

    // Just after each rising edge: fold in the accept of that edge, then check flow-control state
    // against the number of operands the model holds.
    task automatic tick();
        @(posedge clk);
        #1;
        if (pend_valid) begin
            if (pend_illegal) begin
                exp_sel_err = 1'b1;
                if (exp_cnt < 255) exp_cnt++;
            end
            pend_valid = 1'b0;
        end
        check("in_ready", 32'(in_ready), 32'(q.size() < 2));
        check("out_valid", 32'(out_valid), 32'(q.size() != 0));
        check("sel_err", 32'(sel_err), 32'(exp_sel_err));
        check("err_cnt", 32'(err_cnt), 32'(exp_err_cnt()));
    endtask

    task automatic step(input logic v, input int sel, input logic rdy, input logic [NSRC*WIDTH-1:0] s);
        tick();
        in_valid  = v;
        ALUSrc    = SELW'(sel);
        out_ready = rdy;
        src       = s;
        if (v && in_ready) begin
            q.push_back(ref_operand(s, sel));
            pend_valid   = 1'b1;
            pend_illegal = (sel >= NSRC);
        end
    endtask

    task automatic clear_model();
        q.delete();
        pend_valid  = 1'b0;
        exp_sel_err = 1'b0;
        exp_cnt     = 0;
        last_out    = '0;
    endtask

    task automatic check_reset_state();
        check("rst_op", 32'(op), 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'h1);
        check("rst_sel_err", 32'(sel_err), 32'h0);
        check("rst_err_cnt", 32'(err_cnt), 32'h0);
    endtask

    // One-cycle reset with an illegal select offered in the same cycle: reset must win.
    task automatic do_reset();
        tick();
        rst       = 1'b1;
        in_valid  = 1'b1;
        ALUSrc    = 3'd7;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        clear_model();
        check_reset_state();
    endtask

    // Monitor: the head of the queue must be on op whenever out_valid is high; pop on consume.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    check("op_unexpected", 32'(op), 32'hDEAD_BEEF);
                end else begin
                    check("op", 32'(op), 32'(q[0]));
                    if (out_ready) last_out = q.pop_front();
                end
            end else begin
                check("op_idle_hold", 32'(op), 32'(last_out));
            end
        end
    end

    localparam logic [NSRC*WIDTH-1:0] SRC_A = {16'h3333, 16'h2222, 16'h1111};

    initial begin
        logic [NSRC*WIDTH-1:0] s;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        ALUSrc    = '0;
        src       = '0;
        pend_valid   = 1'b0;
        pend_illegal = 1'b0;
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        clear_model();
        check_reset_state();
        repeat (3) step(1'b0, 0, 1'b1, '0);

        // Back-to-back selects 0,1,2 with the sink always ready.
        for (int i = 0; i < NSRC; i++) step(1'b1, i, 1'b1, SRC_A);
        repeat (3) step(1'b0, 0, 1'b1, SRC_A);

        // Stall: two accepts fill output register and skid, then drain.
        step(1'b1, 0, 1'b0, {16'h0, 16'h0, 16'hAAAA});
        step(1'b1, 1, 1'b0, {16'h0, 16'hBBBB, 16'h0});
        repeat (3) step(1'b0, 0, 1'b0, '0);
        repeat (4) step(1'b0, 0, 1'b1, '0);

        // Illegal select yields zero and sets the sticky flag.
        step(1'b1, 3, 1'b1, SRC_A);
        repeat (2) step(1'b0, 0, 1'b1, SRC_A);
        for (int i = 0; i < 300; i++) step(1'b1, 3 + (i % 5), 1'b1, SRC_A);
        repeat (3) step(1'b0, 0, 1'b1, SRC_A);

        // Fill the skid, reset mid-flight, then a fresh transfer.
        do_reset();
        step(1'b1, 0, 1'b0, SRC_A);
        step(1'b1, 1, 1'b0, SRC_A);
        step(1'b0, 0, 1'b0, SRC_A);
        do_reset();
        step(1'b1, 2, 1'b1, {16'h1234, 16'h0, 16'h0});
        repeat (3) step(1'b0, 0, 1'b1, '0);

        // Random traffic with occasional illegal selects.
        for (int i = 0; i < 10000; i++) begin
            int sel;
            s   = {16'($urandom), 32'($urandom)};
            sel = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, NSRC - 1))
                                             : int'($urandom_range(NSRC, 7));
            step(($urandom_range(0, 3) != 0), sel, ($urandom_range(0, 2) != 0), s);
        end
        repeat (4) step(1'b0, 0, 1'b1, '0);
        check("drained", 32'(q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
